hex_event_reader: RTL and testbench
===================================

HEX_EVENT_READER -- requirements
Module: hex_event_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 256, event memory depth in 64-bit words.
REQ-002 SHALL have parameter AW, default $clog2(DEPTH), memory address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse to begin draining one frame.
REQ-006 SHALL have port write_count  input  32  number of valid event words written by the producer.
REQ-007 SHALL have port cull_depth  input  8  depth threshold for culling (used only when HEX_READER_CULL_EN is defined).
REQ-008 SHALL have port mem_rd_en  output  1  memory read strobe.
REQ-009 SHALL have port mem_addr  output  AW  read address.
REQ-010 SHALL have port mem_rdata  input  64  read data, valid exactly one cycle after mem_rd_en.
REQ-011 SHALL have ports out_valid output 1 / out_ready input 1  event stream handshake.
REQ-012 SHALL have ports out_q output 16 signed, out_r output 16 signed, out_depth output 8, out_material output 8  decoded event fields.
REQ-013 SHALL have ports busy output 1, done output 1 (one-cycle pulse), read_count output 32 (events presented), cull_count output 32 (events dropped).

Function
REQ-014 SHALL decode each word as [15:0] q, [31:16] r, [39:32] depth, [47:40] material, [63:48] reserved and ignored.
REQ-015 SHALL latch N = min(write_count, DEPTH) when start is sampled in IDLE.
REQ-016 SHALL implement FSM IDLE -> FETCH -> CAPTURE -> PRESENT -> (FETCH | DONE) -> IDLE.
REQ-017 FETCH: SHALL drive mem_rd_en=1 and mem_addr=current index for exactly one cycle, then go to CAPTURE.
REQ-018 CAPTURE: SHALL register the decoded mem_rdata fields, then go to PRESENT.
REQ-019 PRESENT: SHALL hold out_valid=1 and keep all fields stable until out_valid && out_ready; on that cycle it SHALL increment read_count and the index, then go to FETCH if index+1 < N, otherwise to DONE.
REQ-020 First out_valid SHALL rise 3 cycles after the start edge; back-to-back events with out_ready held high SHALL be spaced 3 cycles apart.
REQ-021 DONE: SHALL pulse done for one cycle and return to IDLE; busy SHALL be 1 in every state except IDLE.
REQ-022 start with N=0 SHALL go IDLE -> DONE directly, with no read and done one cycle after the start edge.
REQ-023 start while busy SHALL be ignored; write_count changes after latching SHALL be ignored.
REQ-024 read_count and cull_count SHALL clear on an accepted start; the index SHALL never reach DEPTH, so there is no address wrap.
REQ-025 mem_rd_en SHALL be 0 in every state other than FETCH; out_valid SHALL be 0 outside PRESENT.

Reset
REQ-026 reset_n low SHALL immediately force IDLE and set mem_rd_en, mem_addr, out_valid, out_q, out_r, out_depth, out_material, busy, done, read_count and cull_count to 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; an in-flight read SHALL be discarded and no done pulse emitted.

Configuration
REQ-028 With HEX_READER_CULL_EN defined, CAPTURE SHALL drop an event whose depth > cull_depth: increment cull_count, skip PRESENT, and go to FETCH or DONE by the same index rule.
REQ-029 Without HEX_READER_CULL_EN, every event SHALL be presented, cull_depth SHALL be ignored, and cull_count SHALL stay 0.

Structure
REQ-030 Package hex_event_pkg SHALL hold the packed hex_event_t, the field bit offsets and the reader state enum, all shared with the writer.
REQ-031 Combinational sub-module hex_event_unpack SHALL split a 64-bit word into hex_event_t.

Verification
REQ-032 Three words, write_count=3, out_ready=1 -> three events in address order 0,1,2, out_valid at cycles 3,6,9 after start, done pulse, read_count=3.
REQ-033 Word 0x0000_0507_FFFE_0003 -> q=3, r=-2, depth=7, material=5.
REQ-034 out_ready held 0 for 10 cycles during PRESENT -> fields stable, no further mem_rd_en, accept on the first ready cycle.
REQ-035 write_count=0 -> no mem_rd_en, done one cycle after start; write_count=300 with DEPTH=256 -> exactly 256 events.
REQ-036 CULL_EN, cull_depth=4, depths {2,9,4} -> events with depths 2 and 4 presented, cull_count=1, read_count=2.
REQ-037 reset_n dropped while PRESENT -> out_valid=0 immediately, IDLE, no done pulse; a new start runs a clean frame.

Source files
------------

// File: rtl/hex_event_pkg.sv
// Shared definitions for the hex event writer/reader pair: packed event
// layout, field bit offsets and the reader state encoding.
package hex_event_pkg;

  localparam int HEX_Q_LSB     = 0;
  localparam int HEX_R_LSB     = 16;
  localparam int HEX_DEPTH_LSB = 32;
  localparam int HEX_MAT_LSB   = 40;
  localparam int HEX_RSVD_LSB  = 48;

  typedef struct packed {
    logic [15:0]        reserved;
    logic [7:0]         material;
    logic [7:0]         depth;
    logic signed [15:0] r;
    logic signed [15:0] q;
  } hex_event_t;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_FETCH,
    RD_CAPTURE,
    RD_PRESENT,
    RD_DONE
  } reader_state_t;

endpackage

// File: rtl/hex_event_unpack.sv
// Splits one 64-bit event memory word into its named fields.
module hex_event_unpack
  import hex_event_pkg::*;
(
  input  logic [63:0] word,
  output hex_event_t  evt
);

  assign evt.q        = word[HEX_Q_LSB     +: 16];
  assign evt.r        = word[HEX_R_LSB     +: 16];
  assign evt.depth    = word[HEX_DEPTH_LSB +: 8];
  assign evt.material = word[HEX_MAT_LSB   +: 8];
  assign evt.reserved = word[HEX_RSVD_LSB  +: 16];

endmodule

// File: rtl/hex_event_reader.sv
// Drains one frame of hex events from a synchronous-read memory and presents
// them on a valid/ready stream.
// Optional feature: define HEX_READER_CULL_EN to drop events deeper than
// cull_depth instead of presenting them.
//
// state      | meaning
// RD_IDLE    | waiting for start; latches frame length
// RD_FETCH   | read strobe for the current index
// RD_CAPTURE | memory data valid; register fields (or cull)
// RD_PRESENT | out_valid held until out_ready
// RD_DONE    | one-cycle done pulse
module hex_event_reader
  import hex_event_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [31:0]        write_count,
  input  logic [7:0]         cull_depth,
  output logic               mem_rd_en,
  output logic [AW-1:0]      mem_addr,
  input  logic [63:0]        mem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_q,
  output logic signed [15:0] out_r,
  output logic [7:0]         out_depth,
  output logic [7:0]         out_material,
  output logic               busy,
  output logic               done,
  output logic [31:0]        read_count,
  output logic [31:0]        cull_count
);

  reader_state_t state, state_next;
  hex_event_t    evt;
  logic [AW-1:0] idx;
  logic [AW:0]   idx_inc;
  logic [AW:0]   n_lat;
  logic [AW:0]   n_start;
  logic          more_left;
  logic          cull_hit;
  logic          unused_bits;

  hex_event_unpack u_unpack (
    .word (mem_rdata),
    .evt  (evt)
  );

  // Frame length is clamped to the memory depth so the index never wraps.
  assign n_start   = (write_count > 32'(DEPTH)) ? (AW+1)'(DEPTH) : write_count[AW:0];
  assign idx_inc   = {1'b0, idx} + (AW+1)'(1);
  assign more_left = idx_inc < n_lat;
  assign mem_addr  = idx;

`ifdef HEX_READER_CULL_EN
  assign cull_hit    = (state == RD_CAPTURE) && (evt.depth > cull_depth);
  assign unused_bits = ^evt.reserved;
`else
  assign cull_hit    = 1'b0;
  assign unused_bits = ^{evt.reserved, cull_depth};
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RD_IDLE;
    else          state <= state_next;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_next = state;
    mem_rd_en  = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      RD_IDLE: begin
        busy = 1'b0;
        if (start) state_next = (n_start == '0) ? RD_DONE : RD_FETCH;
      end
      RD_FETCH: begin
        mem_rd_en  = 1'b1;
        state_next = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        if (cull_hit) state_next = more_left ? RD_FETCH : RD_DONE;
        else          state_next = RD_PRESENT;
      end
      RD_PRESENT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = more_left ? RD_FETCH : RD_DONE;
      end
      RD_DONE: begin
        done       = 1'b1;
        state_next = RD_IDLE;
      end
      default: state_next = RD_IDLE;
    endcase
  end

  // Frame bookkeeping, captured event fields and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx          <= '0;
      n_lat        <= '0;
      out_q        <= '0;
      out_r        <= '0;
      out_depth    <= '0;
      out_material <= '0;
      read_count   <= '0;
      cull_count   <= '0;
    end else begin
      case (state)
        RD_IDLE: begin
          if (start) begin
            idx        <= '0;
            n_lat      <= n_start;
            read_count <= '0;
            cull_count <= '0;
          end
        end
        RD_CAPTURE: begin
          if (cull_hit) begin
            cull_count <= cull_count + 32'd1;
            if (more_left) idx <= idx_inc[AW-1:0];
          end else begin
            out_q        <= evt.q;
            out_r        <= evt.r;
            out_depth    <= evt.depth;
            out_material <= evt.material;
          end
        end
        RD_PRESENT: begin
          if (out_ready) begin
            read_count <= read_count + 32'd1;
            if (more_left) idx <= idx_inc[AW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_event_reader.sv
// Scoreboard bench for hex_event_reader: a frame-level model pushes expected
// read addresses and events; a negedge monitor pops and compares.
module tb_hex_event_reader;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic [31:0]        write_count;
  logic [7:0]         cull_depth;
  logic               mem_rd_en;
  logic [7:0]         mem_addr;
  logic [63:0]        mem_rdata = '0;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_q;
  logic signed [15:0] out_r;
  logic [7:0]         out_depth;
  logic [7:0]         out_material;
  logic               busy;
  logic               done;
  logic [31:0]        read_count;
  logic [31:0]        cull_count;

  hex_event_reader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .write_count  (write_count),
    .cull_depth   (cull_depth),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_q        (out_q),
    .out_r        (out_r),
    .out_depth    (out_depth),
    .out_material (out_material),
    .busy         (busy),
    .done         (done),
    .read_count   (read_count),
    .cull_count   (cull_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] mem [256];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  // expected event packed as {q, r, depth, material}
  logic [47:0] exp_q[$];
  int          exp_addr[$];
  int          rise_q[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [47:0] held = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares reads and presented events against the scoreboard.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (mem_rd_en) begin
        if (exp_addr.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_read: got addr %0d expected none", mem_addr);
        end else begin
          chk("read_addr", 64'(mem_addr), 64'(exp_addr.pop_front()));
        end
        chk("rd_en_while_valid", 64'(out_valid), 64'd0);
      end
      if (out_valid) begin
        if (prev_valid && !prev_ready)
          chk("hold_stable", {out_q, out_r, out_depth, out_material}, held);
        held = {out_q, out_r, out_depth, out_material};
        if (!prev_valid) rise_q.push_back(cyc);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_event: got %0h expected none", held);
          end else begin
            chk("event", held, exp_q.pop_front());
          end
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
    end
  end

  // Reference model: the frame reads min(wc,256) words in order; each word is
  // split by plain shifts, and deep events are dropped when culling is built in.
  task automatic build_expect(input int wc, output int n, output int npres, output int ncull);
    logic [63:0] w;
    logic [47:0] e;
    bit          culled;
    n = (wc > 256) ? 256 : wc;
    npres = 0;
    ncull = 0;
    for (int i = 0; i < n; i++) begin
      w = mem[i];
      e = {16'((w >> 0) & 64'hFFFF), 16'((w >> 16) & 64'hFFFF),
           8'((w >> 32) & 64'hFF), 8'((w >> 40) & 64'hFF)};
      culled = 1'b0;
`ifdef HEX_READER_CULL_EN
      culled = ((w >> 32) & 64'hFF) > 64'(cull_depth);
`endif
      exp_addr.push_back(i);
      if (culled) ncull++;
      else begin
        exp_q.push_back(e);
        npres++;
      end
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: stall first event 10 cycles
  task automatic run_frame(input int wc, input int mode, input bit intrude);
    int n, npres, ncull, s, wait_c, stall;
    bit ok;
    build_expect(wc, n, npres, ncull);
    done_cnt = 0;
    rise_q.delete();
    stall = 0;
    start = 1'b1;
    write_count = 32'(wc);
    out_ready = (mode != 2);
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    write_count = $urandom;
    for (wait_c = 0; done_cnt == 0 && wait_c < 5000; wait_c++) begin
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (mode == 2) begin
        if (out_valid && stall < 10) begin
          out_ready = 1'b0;
          stall++;
        end else out_ready = 1'b1;
      end
      start = intrude && (wait_c == 5) && busy;
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("frame_timeout", 64'(wait_c < 5000), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("read_count", 64'(read_count), 64'(npres));
    chk("cull_count", 64'(cull_count), 64'(ncull));
    chk("events_left", 64'(exp_q.size()), 64'd0);
    chk("reads_left", 64'(exp_addr.size()), 64'd0);
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("busy_after", 64'(busy), 64'd0);
    if (mode == 2) chk("stall_cycles", 64'(stall), 64'd10);
    if (n == 0) chk("empty_done_lat", 64'(done_cyc - s), 64'd1);
    if (mode == 0 && ncull == 0 && n > 0) begin
      chk("rise_count", 64'(rise_q.size()), 64'(npres));
      if (rise_q.size() > 0) chk("first_valid_lat", 64'(rise_q[0] - s), 64'd3);
      ok = 1'b1;
      for (int k = 1; k < rise_q.size(); k++)
        if (rise_q[k] - rise_q[k-1] != 3) ok = 1'b0;
      chk("spacing", 64'(ok), 64'd1);
    end
  endtask

  initial begin
    int n, npres, ncull, t;
    reset_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    write_count = '0;
    cull_depth = '0;
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {mem_rd_en, out_valid, busy, done, mem_addr,
                        out_q, out_r, out_depth, out_material}, 64'd0);
    chk("rst_counts", {read_count, cull_count}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // three-word frame with a known decode on word 0
    mem[0] = 64'h0000_0507_FFFE_0003;
    cull_depth = 8'd255;
    run_frame(3, 0, 1'b0);

    // depths {2,9,4} against threshold 4
    for (int i = 0; i < 3; i++) mem[i] = {$urandom, $urandom};
    mem[0][39:32] = 8'd2;
    mem[1][39:32] = 8'd9;
    mem[2][39:32] = 8'd4;
    cull_depth = 8'd4;
    run_frame(3, 0, 1'b0);

    run_frame(0, 0, 1'b0);

    cull_depth = 8'd255;
    run_frame(2, 2, 1'b0);

    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    cull_depth = 8'($urandom);
    run_frame(300, 0, 1'b0);

    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
      cull_depth = 8'($urandom);
      run_frame($urandom_range(0, 12), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end

    // reset in PRESENT after two accepted events
    for (int i = 0; i < 8; i++) mem[i] = {$urandom, $urandom};
    cull_depth = 8'd255;
    build_expect(4, n, npres, ncull);
    done_cnt = 0;
    out_ready = 1'b1;
    start = 1'b1;
    write_count = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (t = 0; read_count < 2 && t < 100; t++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    for (t = 0; !out_valid && t < 100; t++) begin
      @(posedge clk); #1;
    end
    chk("reach_present", 64'(out_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_rd", 64'(mem_rd_en), 64'd0);
    chk("rst_mid_fields", {out_q, out_r, out_depth, out_material}, 64'd0);
    chk("rst_mid_counts", {read_count, cull_count}, 64'd0);
    exp_q.delete();
    exp_addr.delete();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("no_done_after_rst", 64'(done_cnt), 64'd0);
    chk("idle_after_rst", 64'(busy), 64'd0);
    for (int i = 0; i < 8; i++) mem[i] = {$urandom, $urandom};
    run_frame(5, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
